// File: rtl/channel_buffer_reader.sv
// channel_buffer_reader: bit-serial reader of the ADAT channel ring buffer.
// Assembles 24-bit samples per channel and tracks pending frames against the writer.
`default_nettype none
`timescale 1ns/1ps

module channel_buffer_reader #(
  parameter int FRAME_BITS = 3,
  parameter int CHAN_BITS  = 3,
  parameter int SLOT_BITS  = 5,
  parameter int AUDIO_BITS = 24
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  frame_done_i,
  input  logic                                  read_data_i,
  output logic [FRAME_BITS+CHAN_BITS+SLOT_BITS-1:0] read_addr_o,
  output logic [AUDIO_BITS-1:0]                 sample_o,
  output logic [CHAN_BITS-1:0]                  channel_o,
  output logic                                  sample_valid_o,
  input  logic                                  sample_ready_i,
  output logic [FRAME_BITS:0]                   level_o,
  output logic                                  overrun_o
);

  localparam int SLOT_W     = 1 << SLOT_BITS;
  localparam int LEVEL_BITS = FRAME_BITS + 1;
  localparam logic [LEVEL_BITS-1:0] FULL_LEVEL = LEVEL_BITS'(1 << FRAME_BITS);
  localparam logic [CHAN_BITS-1:0]  LAST_CHAN  = '1;
  localparam logic [SLOT_BITS-1:0]  LAST_BIT   = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PRESENT = 2'd2} state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   rd_frame;
  logic [CHAN_BITS-1:0]    channel;
  logic [SLOT_BITS-1:0]    bit_idx;
  logic [SLOT_BITS-1:0]    cap_cnt;
  logic                    issue;
  logic                    cap;
  logic [SLOT_W-1:0]       shift;
  logic [LEVEL_BITS-1:0]   pending;

  logic                    accept;
  logic                    retire;
  logic                    full;
  logic [LEVEL_BITS-1:0]   pending_next;
  logic [SLOT_W-1:0]       shift_next;
  logic [SLOT_BITS-1:0]    bit_inc;
  logic [CHAN_BITS-1:0]    chan_inc;
  logic [FRAME_BITS-1:0]   frame_inc;

  assign accept     = sample_valid_o & sample_ready_i;
  assign retire     = accept & (channel == LAST_CHAN);
  assign full       = (pending == FULL_LEVEL);
  assign shift_next = {shift[SLOT_W-2:0], read_data_i};
  assign bit_inc    = bit_idx + SLOT_BITS'(1);
  assign chan_inc   = channel + CHAN_BITS'(1);
  assign frame_inc  = rd_frame + FRAME_BITS'(1);

  assign channel_o  = channel;
  assign level_o    = pending;

  // A frame arriving while full is dropped from the count; the writer has already overwritten it.
  always_comb begin
    pending_next = pending;
    if (frame_done_i && !retire && !full)
      pending_next = pending + LEVEL_BITS'(1);
    else if (retire && !frame_done_i)
      pending_next = pending - LEVEL_BITS'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      rd_frame       <= '0;
      channel        <= '0;
      bit_idx        <= '0;
      cap_cnt        <= '0;
      issue          <= 1'b0;
      cap            <= 1'b0;
      shift          <= '0;
      pending        <= '0;
      read_addr_o    <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      pending   <= pending_next;
      overrun_o <= frame_done_i & full & ~retire;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state       <= FETCH;
            bit_idx     <= '0;
            cap_cnt     <= '0;
            issue       <= 1'b1;
            cap         <= 1'b0;
            read_addr_o <= {rd_frame, channel, {SLOT_BITS{1'b0}}};
          end
        end
        FETCH: begin
          // Read data trails its address by one cycle, so capture runs one step behind issue.
          cap <= issue;
          if (issue) begin
            if (bit_idx == LAST_BIT) begin
              issue <= 1'b0;
            end else begin
              bit_idx     <= bit_inc;
              read_addr_o <= {rd_frame, channel, bit_inc};
            end
          end
          if (cap) begin
            shift   <= shift_next;
            cap_cnt <= cap_cnt + SLOT_BITS'(1);
            if (cap_cnt == LAST_BIT) begin
              sample_o       <= shift_next[SLOT_W-1 -: AUDIO_BITS];
              sample_valid_o <= 1'b1;
              state          <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (accept) begin
            sample_valid_o <= 1'b0;
            bit_idx        <= '0;
            cap_cnt        <= '0;
            issue          <= 1'b1;
            cap            <= 1'b0;
            if (channel != LAST_CHAN) begin
              channel     <= chan_inc;
              state       <= FETCH;
              read_addr_o <= {rd_frame, chan_inc, {SLOT_BITS{1'b0}}};
            end else begin
              channel  <= '0;
              rd_frame <= frame_inc;
              if (pending_next != '0) begin
                state       <= FETCH;
                read_addr_o <= {frame_inc, {CHAN_BITS{1'b0}}, {SLOT_BITS{1'b0}}};
              end else begin
                state <= IDLE;
                issue <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_channel_buffer_reader.sv
// tb_channel_buffer_reader: directed sequence over a randomly filled buffer image,
// checked against a frame/channel/level model of the reader.
`default_nettype none
`timescale 1ns/1ps

module tb_channel_buffer_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done;
  logic        read_data;
  logic        sample_ready;
  logic [10:0] read_addr;
  logic [23:0] sample;
  logic [2:0]  channel;
  logic        sample_valid;
  logic [3:0]  level;
  logic        overrun;

  logic mem [0:2047];

  int checks   = 0;
  int failures = 0;
  int frame_m  = 0;
  int chan_m   = 0;
  int level_m  = 0;

  always #5 clk = ~clk;

  // Buffer RAM with a one-cycle registered read.
  always @(posedge clk) read_data <= mem[read_addr];

  channel_buffer_reader #(
    .FRAME_BITS(3), .CHAN_BITS(3), .SLOT_BITS(5), .AUDIO_BITS(24)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_done_i   (frame_done),
    .read_data_i    (read_data),
    .read_addr_o    (read_addr),
    .sample_o       (sample),
    .channel_o      (channel),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .level_o        (level),
    .overrun_o      (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slot bit b lives at buffer bit b and is the b-th most significant bit of the word.
  function automatic logic [31:0] slot_word(input int f, input int c);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = mem[f*256 + c*32 + b];
    return w;
  endfunction

  task automatic set_slot(input int f, input int c, input logic [31:0] w);
    for (int b = 0; b < 32; b++) mem[f*256 + c*32 + b] = w[31-b];
  endtask

  task automatic pulse_fd();
    bit exp_ovf;
    exp_ovf = (level_m == 8);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    if (!exp_ovf) level_m++;
    chk("overrun_on_fd", {31'd0, overrun}, {31'd0, exp_ovf});
    chk("level_after_fd", {28'd0, level}, level_m);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 80 && sample_valid !== 1'b1; i++) tick();
    chk("valid_timeout", {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic consume_one(input bit fd);
    logic [31:0] w;
    wait_valid();
    w = slot_word(frame_m, chan_m);
    chk("sample", {8'd0, sample}, {8'd0, w[31:8]});
    chk("channel", {29'd0, channel}, chan_m);
    chk("addr_frozen", {21'd0, read_addr}, frame_m*256 + chan_m*32 + 31);
    sample_ready = 1'b1;
    frame_done   = fd;
    tick();
    sample_ready = 1'b0;
    frame_done   = 1'b0;
    chk("valid_drop", {31'd0, sample_valid}, 32'd0);
    if (chan_m == 7) begin
      chan_m  = 0;
      frame_m = (frame_m + 1) % 8;
      if (!fd) level_m--;
    end else begin
      chan_m++;
    end
    chk("level_after_accept", {28'd0, level}, level_m);
    chk("overrun_quiet", {31'd0, overrun}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"},    {21'd0, read_addr}, 32'd0);
    chk({tag, "_sample"},  {8'd0, sample}, 32'd0);
    chk({tag, "_channel"}, {29'd0, channel}, 32'd0);
    chk({tag, "_valid"},   {31'd0, sample_valid}, 32'd0);
    chk({tag, "_level"},   {28'd0, level}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int bad;
    logic [23:0] held_sample;
    logic [2:0]  held_chan;
    logic [10:0] held_addr;
    logic [31:0] w;

    for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom_range(0, 1));
    rst = 1'b1; frame_done = 1'b0; sample_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Idle with no frames committed.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sample_valid !== 1'b0 || level !== 4'd0 || overrun !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // First-sample latency and address sequence.
    set_slot(0, 0, 32'hA5C3_0F7E);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    level_m = 1;
    chk("latency_level", {28'd0, level}, 32'd1);
    tick();
    for (int b = 0; b < 32; b++) begin
      chk("fetch_addr", {21'd0, read_addr}, b);
      tick();
    end
    chk("valid_c34", {31'd0, sample_valid}, 32'd0);
    tick();
    chk("valid_c35", {31'd0, sample_valid}, 32'd1);
    chk("first_sample", {8'd0, sample}, 32'h00A5_C30F);
    chk("first_channel", {29'd0, channel}, 32'd0);
    for (int k = 0; k < 8; k++) consume_one(1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sample_valid !== 1'b0) bad++;
    end
    chk("idle_after_frame", bad, 0);

    // Channel-patterned frame.
    for (int k = 0; k < 8; k++) begin
      w = ($urandom & 32'hFFFF_0000) | (32'(k) << 8) | ($urandom & 32'h0000_00FF);
      set_slot(1, k, w);
    end
    pulse_fd();
    for (int k = 0; k < 8; k++) consume_one(1'b0);

    // Consumer stall holds the presented sample.
    pulse_fd();
    wait_valid();
    held_sample = sample; held_chan = channel; held_addr = read_addr;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sample !== held_sample || channel !== held_chan ||
          read_addr !== held_addr || sample_valid !== 1'b1) bad++;
      if (i % 10 == 9) chk("stall_stable", bad, 0);
    end
    for (int k = 0; k < 8; k++) consume_one(1'b0);

    // Fill to capacity, then one more frame overruns.
    for (int p = 0; p < 9; p++) begin
      pulse_fd();
      tick();
    end
    chk("overrun_single_pulse", {31'd0, overrun}, 32'd0);
    chk("level_full", {28'd0, level}, 32'd8);
    for (int k = 0; k < 7; k++) consume_one(1'b0);
    consume_one(1'b1);

    // Drain all eight pending frames; the read frame pointer wraps.
    for (int k = 0; k < 64; k++) consume_one(1'b0);
    chk("drained_level", {28'd0, level}, 32'd0);

    // Reset in the middle of a fetch.
    pulse_fd();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_reset");
    frame_m = 0; chan_m = 0; level_m = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sample_valid !== 1'b0 || level !== 4'd0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    pulse_fd();
    consume_one(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
